// File: rtl/gpio_pulpino_stream.sv
// gpio_pulpino_stream
//   A FIFO-buffered word bridge between the USB host registers and the
//   PULPino GPIO pins. It moves WORD_W-bit words one LANE_W-bit lane at a time
//   and uses toggle handshakes on both sides.
//
//   Downstream path: the host pushes a word into a DEPTH-entry FIFO. A lane
//   shifter presents that word to PULPino one lane at a time. PULPino can
//   abort the rest of the word.
//
//   Upstream path: an assembler collects the lanes coming from PULPino. It
//   pushes a word of LANES lanes, or a shorter word when PULPino ends it early,
//   into a DEPTH-entry FIFO. The FIFO also stores the lane count of each word.
//
// Optional feature: define GPIO_STREAM_ERR_EN to add the sticky error flags
//   err_o[0] (overflow) and err_o[1] (underflow) and the clear input err_clr_i.
//
// Ports
//   clk, reset_i            clock and synchronous active-high reset
//   host_wr_i/_data_i       push strobe (acts on its rising edge) and the word to push
//   host_rd_i               pop strobe (acts on its rising edge)
//   host_rd_data_o/_len_o   upstream head word and its lane count (0 when empty)
//   down_count_o/up_count_o occupancy of each FIFO
//   gpio_data_in_o          lane presented to PULPino
//   down_io_turn_o          [0] toggles for each new lane; [1] marks the first lane
//   down_valid_o            a word is loaded in the lane shifter
//   down_pulp_turn_i        [0] toggle consumes a lane; [1] aborts the word
//   down_done_o             toggles each time a word retires
//   gpio_data_out_i         lane from PULPino
//   up_pulp_turn_i          [0] toggle means a lane is valid; [1] marks the last lane
//   up_io_turn_o            toggles each time a lane is accepted

module gpio_pulpino_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // The caller only pushes when there is room, counting a pop in the same
  // cycle as room, and only pops when the FIFO is non-empty.
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

module gpio_pulpino_stream #(
  parameter int WORD_W = 32,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 4,
  localparam int LANES = WORD_W / LANE_W,
  localparam int LEN_W = $clog2(LANES + 1),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              host_wr_i,
  input  logic [WORD_W-1:0] host_wr_data_i,
  input  logic              host_rd_i,
  output logic [WORD_W-1:0] host_rd_data_o,
  output logic [LEN_W-1:0]  host_rd_len_o,
  output logic [CNT_W-1:0]  down_count_o,
  output logic [CNT_W-1:0]  up_count_o,
  output logic [LANE_W-1:0] gpio_data_in_o,
  output logic [1:0]        down_io_turn_o,
  output logic              down_valid_o,
  input  logic [1:0]        down_pulp_turn_i,
  output logic              down_done_o,
  input  logic [LANE_W-1:0] gpio_data_out_i,
  input  logic [1:0]        up_pulp_turn_i,
  output logic              up_io_turn_o
`ifdef GPIO_STREAM_ERR_EN
  ,
  output logic [1:0]        err_o,
  input  logic              err_clr_i
`endif
);
  typedef enum logic {D_IDLE, D_LOADED} down_state_t;

  // Host strobe edge detection. The previous-value registers reset to 1, so
  // a strobe that is held high through reset does nothing until it drops.
  logic wr_prev, rd_prev, wr_rise, rd_rise;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
    end else begin
      wr_prev <= host_wr_i;
      rd_prev <= host_rd_i;
    end
  end

  assign wr_rise = host_wr_i & ~wr_prev;
  assign rd_rise = host_rd_i & ~rd_prev;

  // Downstream FIFO and lane shifter
  down_state_t       down_state;
  logic [WORD_W-1:0] down_head;
  logic [WORD_W-1:0] down_rest;
  logic [LEN_W-1:0]  down_lane;
  logic              down_known, down_event, down_pop, down_push, down_room;

  assign down_pop   = (down_state == D_IDLE) && (down_count_o != '0);
  assign down_room  = (down_count_o != CNT_W'(DEPTH)) || down_pop;
  assign down_push  = wr_rise && down_room;
  assign down_event = down_pulp_turn_i[0] != down_known;

  gpio_pulpino_stream_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_down_fifo (
    .clk      (clk),
    .reset_i  (reset_i),
    .push     (down_push),
    .push_data(host_wr_data_i),
    .pop      (down_pop),
    .head     (down_head),
    .count    (down_count_o)
  );

  // down_rest holds the lanes that have not been presented yet. This means
  // the next lane is always in its low bits. down_known follows turn[0] on
  // every cycle, so PULPino toggles seen while IDLE are dropped.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      down_state     <= D_IDLE;
      down_rest      <= '0;
      down_lane      <= '0;
      gpio_data_in_o <= '0;
      down_io_turn_o <= 2'b00;
      down_valid_o   <= 1'b0;
      down_done_o    <= 1'b0;
      down_known     <= down_pulp_turn_i[0];
    end else begin
      down_known <= down_pulp_turn_i[0];
      case (down_state)
        D_IDLE: begin
          if (down_pop) begin
            down_state     <= D_LOADED;
            down_rest      <= down_head >> LANE_W;
            gpio_data_in_o <= down_head[LANE_W-1:0];
            down_io_turn_o <= {1'b1, ~down_io_turn_o[0]};
            down_valid_o   <= 1'b1;
            down_lane      <= LEN_W'(1);
          end
        end
        D_LOADED: begin
          if (down_event) begin
            if (down_pulp_turn_i[1] || (down_lane == LEN_W'(LANES))) begin
              down_state   <= D_IDLE;
              down_valid_o <= 1'b0;
              down_done_o  <= ~down_done_o;
            end else begin
              down_rest      <= down_rest >> LANE_W;
              gpio_data_in_o <= down_rest[LANE_W-1:0];
              down_io_turn_o <= {1'b0, ~down_io_turn_o[0]};
              down_lane      <= down_lane + 1'b1;
            end
          end
        end
        default: down_state <= D_IDLE;
      endcase
    end
  end

  // Upstream assembler and FIFO. New lanes enter at the top. The lowest lane
  // of a full word only exists at the moment the word is pushed, so the
  // assembler register keeps just the upper LANES-1 lanes.
  logic [WORD_W-LANE_W-1:0] up_asm;
  logic [WORD_W-1:0]        up_asm_next, up_word;
  logic [LEN_W-1:0]         up_n, up_n_next;
  logic [31:0]              up_shift;
  logic [WORD_W+LEN_W-1:0]  up_head;
  logic                     up_known, up_event, up_complete, up_room;
  logic                     up_accept, up_push, up_pop;

  assign up_event    = up_pulp_turn_i[0] != up_known;
  assign up_asm_next = {gpio_data_out_i, up_asm};
  assign up_n_next   = up_n + 1'b1;
  assign up_complete = (up_n_next == LEN_W'(LANES)) || up_pulp_turn_i[1];
  assign up_pop      = rd_rise && (up_count_o != '0);
  assign up_room     = (up_count_o != CNT_W'(DEPTH)) || up_pop;
  // A lane that completes a word while the FIFO is full stays pending.
  // Because known is not updated, the toggle is seen again on the next cycle.
  assign up_accept   = up_event && (!up_complete || up_room);
  assign up_push     = up_accept && up_complete;
  assign up_shift    = 32'(LANE_W * (LANES - int'(up_n_next)));
  assign up_word     = up_asm_next >> up_shift;

  gpio_pulpino_stream_fifo #(.WIDTH(WORD_W + LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_up_fifo (
    .clk      (clk),
    .reset_i  (reset_i),
    .push     (up_push),
    .push_data({up_n_next, up_word}),
    .pop      (up_pop),
    .head     (up_head),
    .count    (up_count_o)
  );

  assign {host_rd_len_o, host_rd_data_o} = up_head;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      up_asm       <= '0;
      up_n         <= '0;
      up_io_turn_o <= 1'b0;
      up_known     <= up_pulp_turn_i[0];
    end else if (up_accept) begin
      up_known     <= up_pulp_turn_i[0];
      up_io_turn_o <= ~up_io_turn_o;
      if (up_complete) begin
        up_asm <= '0;
        up_n   <= '0;
      end else begin
        up_asm <= up_asm_next[WORD_W-1:LANE_W];
        up_n   <= up_n_next;
      end
    end
  end

`ifdef GPIO_STREAM_ERR_EN
  // Sticky error flags. If a flag is set and cleared in the same cycle, the set wins.
  logic [1:0] err_set;
  assign err_set = {rd_rise && (up_count_o == '0), wr_rise && !down_room};

  always_ff @(posedge clk) begin
    if (reset_i) begin
      err_o <= 2'b00;
    end else begin
      err_o <= (err_o & ~{2{err_clr_i}}) | err_set;
    end
  end
`endif
endmodule

// File: tb/tb_gpio_pulpino_stream.sv
// tb_gpio_pulpino_stream
//   Self-checking bench for gpio_pulpino_stream. It uses the default
//   parameters WORD_W=32, LANE_W=8 and DEPTH=4. The downstream transfer of one
//   word is driven from a vector table. The overflow, abort, upstream
//   assembly, backpressure and reset cases are written out as directed
//   sequences. The err_o checks are built only when GPIO_STREAM_ERR_EN is
//   defined.

module tb_gpio_pulpino_stream;
  localparam int WORD_W = 32;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        host_wr_i;
  logic [31:0] host_wr_data_i;
  logic        host_rd_i;
  logic [31:0] host_rd_data_o;
  logic [2:0]  host_rd_len_o;
  logic [2:0]  down_count_o;
  logic [2:0]  up_count_o;
  logic [7:0]  gpio_data_in_o;
  logic [1:0]  down_io_turn_o;
  logic        down_valid_o;
  logic [1:0]  down_pulp_turn_i;
  logic        down_done_o;
  logic [7:0]  gpio_data_out_i;
  logic [1:0]  up_pulp_turn_i;
  logic        up_io_turn_o;
`ifdef GPIO_STREAM_ERR_EN
  logic [1:0]  err_o;
  logic        err_clr_i;
`endif

  int checks = 0;
  int errors = 0;

  // Toggle state of the handshakes, as driven by the bench and as expected from the DUT
  logic dt0 = 1'b0;
  logic ut0 = 1'b0;
  logic exp_uack = 1'b0;

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  dturn;
    logic [7:0]  exp_gpio;
    logic [1:0]  exp_turn;
    logic        exp_valid;
    logic        exp_done;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  gpio_pulpino_stream #(.WORD_W(WORD_W), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .host_wr_i       (host_wr_i),
    .host_wr_data_i  (host_wr_data_i),
    .host_rd_i       (host_rd_i),
    .host_rd_data_o  (host_rd_data_o),
    .host_rd_len_o   (host_rd_len_o),
    .down_count_o    (down_count_o),
    .up_count_o      (up_count_o),
    .gpio_data_in_o  (gpio_data_in_o),
    .down_io_turn_o  (down_io_turn_o),
    .down_valid_o    (down_valid_o),
    .down_pulp_turn_i(down_pulp_turn_i),
    .down_done_o     (down_done_o),
    .gpio_data_out_i (gpio_data_out_i),
    .up_pulp_turn_i  (up_pulp_turn_i),
    .up_io_turn_o    (up_io_turn_o)
`ifdef GPIO_STREAM_ERR_EN
    ,
    .err_o           (err_o),
    .err_clr_i       (err_clr_i)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    host_wr_i        = v.wr;
    host_wr_data_i   = v.wdata;
    down_pulp_turn_i = v.dturn;
    tick();
  endtask

  task automatic pushWord(input logic [31:0] data);
    host_wr_data_i = data;
    host_wr_i = 1'b1;
    tick();
    host_wr_i = 1'b0;
    tick();
  endtask

  task automatic popWord();
    host_rd_i = 1'b1;
    tick();
    host_rd_i = 1'b0;
    tick();
  endtask

  task automatic downToggle(input logic abort);
    dt0 = ~dt0;
    down_pulp_turn_i = {abort, dt0};
    tick();
    down_pulp_turn_i[1] = 1'b0;
  endtask

  task automatic sendLane(input logic [7:0] data, input logic last);
    ut0 = ~ut0;
    gpio_data_out_i = data;
    up_pulp_turn_i = {last, ut0};
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " gpio_in"}, 32'(gpio_data_in_o), 32'h0);
    checkOutput({tag, " io_turn"}, 32'(down_io_turn_o), 32'h0);
    checkOutput({tag, " valid"}, 32'(down_valid_o), 32'h0);
    checkOutput({tag, " done"}, 32'(down_done_o), 32'h0);
    checkOutput({tag, " down_count"}, 32'(down_count_o), 32'h0);
    checkOutput({tag, " up_count"}, 32'(up_count_o), 32'h0);
    checkOutput({tag, " up_io_turn"}, 32'(up_io_turn_o), 32'h0);
    checkOutput({tag, " rd_data"}, host_rd_data_o, 32'h0);
    checkOutput({tag, " rd_len"}, 32'(host_rd_len_o), 32'h0);
`ifdef GPIO_STREAM_ERR_EN
    checkOutput({tag, " err"}, 32'(err_o), 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Downstream transfer of 0xDDCCBBAA. The PULPino toggles start from 0.
    vecs[0] = '{1'b1, 32'hDDCCBBAA, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 3'd1};
    vecs[1] = '{1'b1, 32'hDDCCBBAA, 2'b00, 8'hAA, 2'b11, 1'b1, 1'b0, 3'd0};
    vecs[2] = '{1'b0, 32'h0,        2'b01, 8'hBB, 2'b00, 1'b1, 1'b0, 3'd0};
    vecs[3] = '{1'b0, 32'h0,        2'b00, 8'hCC, 2'b01, 1'b1, 1'b0, 3'd0};
    vecs[4] = '{1'b0, 32'h0,        2'b01, 8'hDD, 2'b00, 1'b1, 1'b0, 3'd0};
    vecs[5] = '{1'b0, 32'h0,        2'b00, 8'hDD, 2'b00, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{1'b0, 32'h0,        2'b00, 8'hDD, 2'b00, 1'b0, 1'b1, 3'd0};

    reset_i = 1'b1;
    host_wr_i = 1'b0;
    host_wr_data_i = '0;
    host_rd_i = 1'b0;
    down_pulp_turn_i = 2'b00;
    gpio_data_out_i = '0;
    up_pulp_turn_i = 2'b00;
`ifdef GPIO_STREAM_ERR_EN
    err_clr_i = 1'b0;
`endif
    tick();
    tick();
    checkAllZero("reset");
    reset_i = 1'b0;
    tick();

    $display("[TB] table: downstream word 0xDDCCBBAA");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d gpio_in", i), 32'(gpio_data_in_o), 32'(vecs[i].exp_gpio));
      checkOutput($sformatf("vec%0d io_turn", i), 32'(down_io_turn_o), 32'(vecs[i].exp_turn));
      checkOutput($sformatf("vec%0d valid", i), 32'(down_valid_o), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d done", i), 32'(down_done_o), 32'(vecs[i].exp_done));
      checkOutput($sformatf("vec%0d down_count", i), 32'(down_count_o), 32'(vecs[i].exp_cnt));
    end
    dt0 = 1'b0;

    $display("[TB] sequence: overflow while shifter stalled");
    pushWord(32'h44332211);
    checkOutput("stall load gpio", 32'(gpio_data_in_o), 32'h11);
    pushWord(32'hA4A3A2A1);
    pushWord(32'hB4B3B2B1);
    pushWord(32'hC4C3C2C1);
    pushWord(32'hD4D3D2D1);
    pushWord(32'hE4E3E2E1);
    checkOutput("overflow down_count", 32'(down_count_o), 32'd4);
    checkOutput("overflow gpio held", 32'(gpio_data_in_o), 32'h11);
    checkOutput("overflow io_turn", 32'(down_io_turn_o), 32'h3);
`ifdef GPIO_STREAM_ERR_EN
    checkOutput("overflow err", 32'(err_o), 32'h1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    checkOutput("err clear", 32'(err_o), 32'h0);
`endif
    downToggle(1'b0);
    downToggle(1'b0);
    downToggle(1'b0);
    checkOutput("drain lane4", 32'(gpio_data_in_o), 32'h44);
    downToggle(1'b0);
    checkOutput("drain done", 32'(down_done_o), 32'h0);
    checkOutput("drain valid", 32'(down_valid_o), 32'h0);
    tick();
    checkOutput("W1 gpio", 32'(gpio_data_in_o), 32'hA1);
    checkOutput("W1 io_turn", 32'(down_io_turn_o), 32'h3);
    checkOutput("W1 down_count", 32'(down_count_o), 32'd3);

    $display("[TB] sequence: abort on lane 2");
    downToggle(1'b0);
    checkOutput("abort lane2 gpio", 32'(gpio_data_in_o), 32'hA2);
    checkOutput("abort lane2 io_turn", 32'(down_io_turn_o), 32'h0);
    downToggle(1'b1);
    checkOutput("abort done", 32'(down_done_o), 32'h1);
    checkOutput("abort valid", 32'(down_valid_o), 32'h0);
    tick();
    checkOutput("W2 gpio", 32'(gpio_data_in_o), 32'hB1);
    checkOutput("W2 io_turn", 32'(down_io_turn_o), 32'h3);
    checkOutput("W2 valid", 32'(down_valid_o), 32'h1);
    checkOutput("W2 down_count", 32'(down_count_o), 32'd2);
    downToggle(1'b1);
    tick();
    checkOutput("W3 gpio", 32'(gpio_data_in_o), 32'hC1);
    downToggle(1'b1);
    tick();
    checkOutput("W4 gpio", 32'(gpio_data_in_o), 32'hD1);
    downToggle(1'b1);
    tick();
    checkOutput("dropped W5 valid", 32'(down_valid_o), 32'h0);
    checkOutput("dropped W5 count", 32'(down_count_o), 32'd0);
    checkOutput("final done", 32'(down_done_o), 32'h0);

    $display("[TB] sequence: upstream truncated word");
    sendLane(8'h11, 1'b0);
    exp_uack = ~exp_uack;
    checkOutput("up lane1 ack", 32'(up_io_turn_o), 32'(exp_uack));
    sendLane(8'h22, 1'b0);
    exp_uack = ~exp_uack;
    checkOutput("up lane2 ack", 32'(up_io_turn_o), 32'(exp_uack));
    checkOutput("up partial count", 32'(up_count_o), 32'd0);
    sendLane(8'h33, 1'b1);
    exp_uack = ~exp_uack;
    checkOutput("up lane3 ack", 32'(up_io_turn_o), 32'(exp_uack));
    checkOutput("up short count", 32'(up_count_o), 32'd1);
    checkOutput("up short data", host_rd_data_o, 32'h00332211);
    checkOutput("up short len", 32'(host_rd_len_o), 32'd3);

    $display("[TB] sequence: upstream backpressure");
    for (int w = 4; w <= 6; w++) begin
      for (int k = 0; k < 4; k++) begin
        sendLane(8'(w * 16 + k), 1'b0);
        exp_uack = ~exp_uack;
      end
    end
    checkOutput("up full count", 32'(up_count_o), 32'd4);
    checkOutput("up full head", host_rd_data_o, 32'h00332211);
    for (int k = 0; k < 3; k++) begin
      sendLane(8'(8'h70 + k), 1'b0);
      exp_uack = ~exp_uack;
    end
    checkOutput("up partial ack while full", 32'(up_io_turn_o), 32'(exp_uack));
    sendLane(8'h73, 1'b0);
    tick();
    tick();
    checkOutput("up stalled ack", 32'(up_io_turn_o), 32'(exp_uack));
    checkOutput("up stalled count", 32'(up_count_o), 32'd4);
    host_rd_i = 1'b1;
    tick();
    host_rd_i = 1'b0;
    exp_uack = ~exp_uack;
    checkOutput("up released ack", 32'(up_io_turn_o), 32'(exp_uack));
    checkOutput("up released count", 32'(up_count_o), 32'd4);
    checkOutput("up head W4", host_rd_data_o, 32'h43424140);
    checkOutput("up head W4 len", 32'(host_rd_len_o), 32'd4);
    tick();
    popWord();
    checkOutput("up head W5", host_rd_data_o, 32'h53525150);
    checkOutput("up count 3", 32'(up_count_o), 32'd3);
    popWord();
    checkOutput("up head W6", host_rd_data_o, 32'h63626160);
    popWord();
    checkOutput("up head W7", host_rd_data_o, 32'h73727170);
    checkOutput("up head W7 len", 32'(host_rd_len_o), 32'd4);
    checkOutput("up count 1", 32'(up_count_o), 32'd1);
    popWord();
    checkOutput("up empty data", host_rd_data_o, 32'h0);
    checkOutput("up empty len", 32'(host_rd_len_o), 32'd0);
    popWord();
    checkOutput("up underflow count", 32'(up_count_o), 32'd0);
`ifdef GPIO_STREAM_ERR_EN
    checkOutput("underflow err", 32'(err_o), 32'h2);
`endif

    $display("[TB] sequence: reset mid-word with host_wr_i held");
    pushWord(32'h12345678);
    downToggle(1'b0);
    checkOutput("pre-reset gpio", 32'(gpio_data_in_o), 32'h56);
    sendLane(8'h99, 1'b0);
    host_wr_data_i = 32'hCAFEF00D;
    host_wr_i = 1'b1;
    tick();
    checkOutput("pre-reset down_count", 32'(down_count_o), 32'd1);
    reset_i = 1'b1;
    tick();
    tick();
    checkAllZero("mid reset");
    reset_i = 1'b0;
    tick();
    tick();
    checkOutput("post-reset held wr count", 32'(down_count_o), 32'd0);
    checkOutput("post-reset valid", 32'(down_valid_o), 32'h0);
    checkOutput("post-reset up ack", 32'(up_io_turn_o), 32'h0);
    checkOutput("post-reset io_turn", 32'(down_io_turn_o), 32'h0);
    host_wr_i = 1'b0;
    tick();
    host_wr_i = 1'b1;
    tick();
    checkOutput("repush count", 32'(down_count_o), 32'd1);
    tick();
    checkOutput("repush gpio", 32'(gpio_data_in_o), 32'h0D);
    checkOutput("repush io_turn", 32'(down_io_turn_o), 32'h3);
    host_wr_i = 1'b0;
    sendLane(8'h5A, 1'b1);
    checkOutput("post-reset lane ack", 32'(up_io_turn_o), 32'h1);
    checkOutput("post-reset up data", host_rd_data_o, 32'h0000005A);
    checkOutput("post-reset up len", 32'(host_rd_len_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_pulpino_stream.md
# gpio_pulpino_stream

Parametrised, FIFO-buffered successor to the CW305 USB↔PULPino GPIO byte bridge. It moves WORD_W-bit words between the USB register side and the PULPino GPIO pins, one LANE_W-bit lane at a time, using toggle handshakes. Each direction has a DEPTH-entry word FIFO, so the host can queue several words without waiting for the core. The PULPino side can end a word early: a truncated upstream word is pushed with its lane count, and an abort on the downstream side discards the rest of the current word.

## Interface
- WORD_W, 32, word width; must be a multiple of LANE_W
- LANE_W, 8, GPIO lane width; LANES = WORD_W/LANE_W, must be ≥2
- DEPTH, 4, entries per FIFO; power of two, ≥2
- clk  in  1  single clock; all inputs synchronous to it
- reset_i  in  1  synchronous, active-high reset
- host_wr_i  in  1  push strobe; one push per rising edge (0→1)
- host_wr_data_i  in  WORD_W  word to push downstream
- host_rd_i  in  1  pop strobe; one pop per rising edge
- host_rd_data_o  out  WORD_W  upstream FIFO head word; 0 when empty
- host_rd_len_o  out  clog2(LANES+1)  valid lanes in the head word; 0 when empty
- down_count_o  out  clog2(DEPTH+1)  downstream FIFO occupancy
- up_count_o  out  clog2(DEPTH+1)  upstream FIFO occupancy
- gpio_data_in_o  out  LANE_W  lane presented to PULPino
- down_io_turn_o  out  2  [0] toggles when a new lane is presented; [1]=1 while the first lane of a word is presented
- down_valid_o  out  1  a word is loaded in the lane shifter
- down_pulp_turn_i  in  2  [0] toggle = lane consumed; [1]=1 at the toggle = abort the rest of the word
- down_done_o  out  1  toggles when a word retires (completed or aborted)
- gpio_data_out_i  in  LANE_W  lane from PULPino
- up_pulp_turn_i  in  2  [0] toggle = lane valid; [1]=1 at the toggle = last lane of the word
- up_io_turn_o  out  1  toggles when a lane is accepted
- err_o  out  2  [0] overflow, [1] underflow; present only with GPIO_STREAM_ERR_EN
- err_clr_i  in  1  clears err_o; present only with GPIO_STREAM_ERR_EN

## Operation
- **Strobe edge detect.** Previous-value registers for host_wr_i and host_rd_i reset to 1. A strobe held high through reset therefore causes no action until it goes low and high again.
- **Handshake event.** An event is `turn_i[0] != known`, where `known` is a register holding the last seen value of turn[0]. On reset, each `known` register loads its turn[0] input, so reset never produces a spurious event.
- **Downstream push.** A host_wr_i rising edge with down_count_o<DEPTH writes host_wr_data_i into the FIFO. The same edge with the FIFO full drops the word.
- **Downstream shifter states:**
  - IDLE→LOADED when the FIFO is non-empty: pop the head, down_valid_o=1, down_io_turn_o={1,~[0]}, gpio_data_in_o = word[LANE_W-1:0], lane counter = 1.
  - LOADED, event with [1]=0 and lane counter<LANES: shift the word right by LANE_W, toggle io_turn[0], clear io_turn[1], increment the lane counter.
  - LOADED, event with [1]=0 and lane counter==LANES: retire the word and toggle down_done_o.
  - LOADED, event with [1]=1: retire the word and toggle down_done_o.
  - On retire, go to IDLE. If the FIFO is non-empty, the next word loads on the following cycle.
- **Upstream assembler.**
  - On an event, if the upstream FIFO has room, or will have room because an accepted word does not complete: shift in `asm = {gpio_data_out_i, asm[WORD_W-1:LANE_W]}`, increment the lane count n, and toggle up_io_turn_o.
  - If n reaches LANES, or turn[1]=1, push `asm >> (LANE_W*(LANES-n))` with length n. This places the first lane at bits [LANE_W-1:0]. Then clear asm and n.
  - If the lane would complete a word and the FIFO is full, do not update `known` and do not ack. The event stays pending until a pop frees space. This is the only PULPino backpressure.
- **Host pop.** A host_rd_i rising edge on a non-empty FIFO advances the head. On an empty FIFO it is ignored.
- **Simultaneous operations.** Push and pop on the same FIFO in the same cycle are both performed, including when the FIFO is full.
- **Reset mid-operation.** Reset clears both FIFOs, the shifter, the assembler and all outputs. Partial words are lost.

## Timing
- Reset values: all outputs 0, down_io_turn_o=2'b00, counts 0.
- Host push sampled at edge N: down_count_o updates after N.
  - If the shifter is IDLE, the first lane appears after N+1.
- Downstream event sampled at edge M: next lane, or retire and down_done_o toggle, visible after M.
- Upstream event accepted at edge M: up_io_turn_o toggles after M; the word is visible on host_rd_data_o after M.
- Pop at edge N: new head visible after N.
- No combinational path from any input to any output.

## Configuration
- `GPIO_STREAM_ERR_EN` defined: err_o and err_clr_i exist.
  - err_o[0] sets sticky on a dropped push.
  - err_o[1] sets sticky on a pop while empty.
  - err_clr_i clears both; a set in the same cycle wins over the clear.
- Undefined: both ports are absent and drops/ignored pops are silent. Data-path behaviour is identical.

## Test plan
- Push 0xDDCCBBAA; PULPino toggles 4× with [1]=0 → lanes AA, BB, CC, DD; io_turn[1]=1 only on AA; down_done_o toggles once; down_valid_o falls.
- Push 5 words with DEPTH=4 and the shifter stalled → 4 accepted, 1 dropped, err_o[0]=1; err_clr_i → err_o=0.
- Upstream lanes 11, 22, then 33 with [1]=1 → host_rd_data_o=0x00332211, host_rd_len_o=3.
- Upstream FIFO full, 4th lane event arrives → no up_io_turn_o toggle; after host pop → lane accepted, word pushed next cycle.
- Downstream abort on lane 2 ([1]=1) → word retires, down_done_o toggles, next FIFO word loads with io_turn[1]=1.
- reset_i asserted mid-word with host_wr_i held high → all outputs 0; no push until host_wr_i goes 0→1.
